// File: rtl/logic_unit_pkg.sv
// Shared opcode and FSM state definitions for the logic-unit arbiter, the logic unit and its bench.
package logic_unit_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/logic_unit.sv
// Combinational W-bit gate unit. All eight opcodes are defined; NOT and PASS act on operand a only.
module logic_unit
  import logic_unit_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  always_comb begin
    y = a;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_PASS: y = a;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic_unit among NREQ requesters, one operation in flight.
// Optional per-requester saturating grant counters are enabled with `define LOGIC_ARB_STATS_EN.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int CW   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*3-1:0]        req_op,
  input  logic [NREQ*W-1:0]        req_a,
  input  logic [NREQ*W-1:0]        req_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [$clog2(NREQ)-1:0]  res_id,
  output logic [W-1:0]             res_data
`ifdef LOGIC_ARB_STATS_EN
  ,
  output logic [NREQ*CW-1:0]       grant_cnt
`endif
);

  localparam int IW = $clog2(NREQ);

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_found;
  logic            accept;
  logic [2:0]      op_p0;
  logic [W-1:0]    a_p0, b_p0;
  logic [IW-1:0]   id_p0;
  logic [W-1:0]    y;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    int            idx;
    logic [IW-1:0] idx_w;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = IW'(idx);
      if (!gnt_found && req_valid[idx_w]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx_w;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (gnt_found) begin
          req_ready = NREQ'(1) << gnt_idx;
          accept    = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (res_valid && res_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0: operands of the granted requester
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0 <= req_op[3*gnt_idx +: 3];
      a_p0  <= req_a[W*gnt_idx +: W];
      b_p0  <= req_b[W*gnt_idx +: W];
      id_p0 <= gnt_idx;
    end
  end

  logic_unit #(.W(W)) u_logic_unit (
    .op (op_p0),
    .a  (a_p0),
    .b  (b_p0),
    .y  (y)
  );

  // Response stage: registered result, held until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
    end else begin
      if (accept) rr_ptr <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      if (state == ST_EXEC) begin
        res_data  <= y;
        res_id    <= id_p0;
        res_valid <= 1'b1;
      end else if (state == ST_RESP && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef LOGIC_ARB_STATS_EN
  logic [CW-1:0] cnt_q [NREQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else if (accept && cnt_q[gnt_idx] != '1) begin
      cnt_q[gnt_idx] <= cnt_q[gnt_idx] + 1'b1;
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt_out
    assign grant_cnt[CW*gi +: CW] = cnt_q[gi];
  end
`else
  // CW only sizes the counters; this keeps the parameter referenced when they are absent.
  if (CW > 0) begin : g_no_stats
  end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: table of single ops, round-robin, reset, backpressure, wrap and stats.
module tb_logic_unit_arbiter;
  import logic_unit_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int CW   = 2;
  localparam int IW   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*3-1:0] req_op;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              res_valid;
  logic              res_ready;
  logic [IW-1:0]     res_id;
  logic [W-1:0]      res_data;
`ifdef LOGIC_ARB_STATS_EN
  logic [NREQ*CW-1:0] grant_cnt;
`endif

  always #5 clk = ~clk;

  logic_unit_arbiter #(.NREQ(NREQ), .W(W), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_data  (res_data)
`ifdef LOGIC_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  typedef struct {
    int          id;
    logic [2:0]  op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  typedef struct {
    logic [IW-1:0] id;
    logic [W-1:0]  data;
  } exp_t;

  vec_t  vecs [9];
  exp_t  sb [$];
  int    grant_log [$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc_n = 0;
  int    acc_cyc = 0;
  int    rv_cyc = 0;
  logic  rv_prev = 1'b0;
  logic [NREQ-1:0] acc = '0;
  logic [NREQ-1:0] keep = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Independent reference: per-bit truth table indexed by {a_i, b_i}.
  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [3:0]   tt;
    logic [W-1:0] y;
    case (op)
      OP_AND:  tt = 4'b1000;
      OP_OR:   tt = 4'b1110;
      OP_NOT:  tt = 4'b0011;
      OP_XOR:  tt = 4'b0110;
      OP_NAND: tt = 4'b0111;
      OP_NOR:  tt = 4'b0001;
      OP_XNOR: tt = 4'b1001;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < W; i++) y[i] = tt[{a[i], b[i]}];
    return y;
  endfunction

  task automatic monitor();
    exp_t e;
    cyc_n++;
    if (req_ready != '0) begin
      chk("req_ready_onehot", 32'($onehot(req_ready)), 32'd1);
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          grant_log.push_back(i);
          acc[i] = 1'b1;
        end
      end
      acc_cyc = cyc_n;
    end
    if (res_valid && !rv_prev) rv_cyc = cyc_n;
    if (res_valid) chk("req_ready_while_busy", 32'(req_ready), 32'd0);
    if (res_valid && res_ready) begin
      if (sb.size() == 0) begin
        fail_now($sformatf("unexpected_response id=%0d data=0x%0h, required none", res_id, res_data));
      end else begin
        e = sb.pop_front();
        chk("res_id", 32'(res_id), 32'(e.id));
        chk("res_data", 32'(res_data), 32'(e.data));
      end
    end
    rv_prev = res_valid;
  endtask

  // One clock: sample at the falling edge, then return just after the rising edge.
  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (acc[i] && !keep[i]) req_valid[i] = 1'b0;
    acc = '0;
  endtask

  task automatic drive(input int id, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    req_op[3*id +: 3] = op;
    req_a[W*id +: W]  = a;
    req_b[W*id +: W]  = b;
    req_valid[id]     = 1'b1;
  endtask

  task automatic push_exp(input int id, input logic [W-1:0] data);
    sb.push_back(exp_t'{IW'(id), data});
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while ((sb.size() != 0 || req_valid != '0) && k < budget) begin
      cyc();
      k++;
    end
    if (k >= budget) fail_now({name, " timeout: response not delivered, required within budget"});
  endtask

  task automatic wait_res_valid(input string name);
    int k = 0;
    while (!res_valid && k < 20) begin
      cyc();
      k++;
    end
    if (!res_valid) fail_now({name, " timeout: res_valid=0, required 1"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2, OP_XOR,  8'hF0, 8'h3C, 8'hCC};
    vecs[1] = '{0, OP_AND,  8'hF0, 8'h3C, 8'h30};
    vecs[2] = '{1, OP_OR,   8'hF0, 8'h3C, 8'hFC};
    vecs[3] = '{3, OP_NOT,  8'h5A, 8'h00, 8'hA5};
    vecs[4] = '{0, OP_NAND, 8'hFF, 8'h0F, 8'hF0};
    vecs[5] = '{1, OP_NOR,  8'h0C, 8'h30, 8'hC3};
    vecs[6] = '{2, OP_XNOR, 8'hAA, 8'h0F, 8'h5A};
    vecs[7] = '{3, OP_PASS, 8'h81, 8'hFF, 8'h81};
    vecs[8] = '{1, OP_NOT,  8'h00, 8'hFF, 8'hFF};

    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;

    #3;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_res_valid", 32'(res_valid), 32'd0);
    chk("reset_res_id", 32'(res_id), 32'd0);
    chk("reset_res_data", 32'(res_data), 32'd0);
`ifdef LOGIC_ARB_STATS_EN
    chk("reset_grant_cnt", 32'(grant_cnt), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset while a result is held: in-flight op dropped, rr_ptr back to 0.
    res_ready = 1'b0;
    drive(1, OP_AND, 8'hFF, 8'h0F);
    push_exp(1, 8'h0F);
    wait_res_valid("reset_setup");
    #2 rst_n = 1'b0;
    #1;
    chk("midop_reset_res_valid", 32'(res_valid), 32'd0);
    chk("midop_reset_req_ready", 32'(req_ready), 32'd0);
    chk("midop_reset_res_data", 32'(res_data), 32'd0);
    chk("midop_reset_res_id", 32'(res_id), 32'd0);
    sb.delete();
    req_valid = '0;
    acc       = '0;
    @(posedge clk);
    #1 rst_n  = 1'b1;
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("no_response_after_reset", 32'(res_valid), 32'd0);
    end

    // Round robin with all requesters held valid: grants 0,1,2,3,0.
    keep = '1;
    grant_log.delete();
    for (int k = 0; k < 5; k++) push_exp(k % NREQ, model(OP_NAND, 8'hFF, 8'h0F));
    for (int i = 0; i < NREQ; i++) drive(i, OP_NAND, 8'hFF, 8'h0F);
    begin
      int k = 0;
      while (sb.size() != 0 && k < 40) begin
        cyc();
        k++;
      end
      if (sb.size() != 0) fail_now("round_robin timeout: results missing");
    end
    req_valid = '0;
    keep      = '0;
    for (int k = 0; k < 5; k++)
      chk("rr_grant_order", (k < grant_log.size()) ? 32'(grant_log[k]) : 32'hFFFF_FFFF, 32'(k % NREQ));

    // Table of single operations, each checked for grant, result and 2-cycle latency.
    for (int v = 0; v < 9; v++) begin
      grant_log.delete();
      drive(vecs[v].id, vecs[v].op, vecs[v].a, vecs[v].b);
      push_exp(vecs[v].id, vecs[v].exp);
      wait_drain("vector", 20);
      chk("vec_grant_id", (grant_log.size() == 1) ? 32'(grant_log[0]) : 32'hFFFF_FFFF,
          32'(vecs[v].id));
      chk("vec_latency", 32'(rv_cyc - acc_cyc), 32'd2);
    end

    // Backpressure: result held stable for 5 cycles while another requester waits.
    begin
      logic [W-1:0]  d_hold;
      logic [IW-1:0] id_hold;
      res_ready = 1'b0;
      drive(0, OP_OR, 8'h12, 8'h40);
      push_exp(0, 8'h52);
      wait_res_valid("backpressure");
      d_hold  = res_data;
      id_hold = res_id;
      drive(3, OP_AND, 8'hF0, 8'h3C);
      push_exp(3, 8'h30);
      for (int k = 0; k < 5; k++) begin
        cyc();
        chk("bp_res_valid", 32'(res_valid), 32'd1);
        chk("bp_res_data", 32'(res_data), 32'(d_hold));
        chk("bp_res_id", 32'(res_id), 32'(id_hold));
        chk("bp_req_ready", 32'(req_ready), 32'd0);
      end
      res_ready = 1'b1;
      wait_drain("backpressure_release", 30);
    end

    // Wrap/skip: rr_ptr=3 with only requester 1 valid grants 1, leaving rr_ptr=2.
    drive(2, OP_PASS, 8'h77, 8'h00);
    push_exp(2, 8'h77);
    wait_drain("wrap_setup", 20);
    grant_log.delete();
    drive(1, OP_NOT, 8'h5A, 8'hFF);
    push_exp(1, 8'hA5);
    wait_drain("wrap", 20);
    chk("wrap_grant", (grant_log.size() == 1) ? 32'(grant_log[0]) : 32'hFFFF_FFFF, 32'd1);
    grant_log.delete();
    drive(1, OP_XOR, 8'h01, 8'h02);
    drive(2, OP_XOR, 8'h04, 8'h08);
    push_exp(2, 8'h0C);
    push_exp(1, 8'h03);
    wait_drain("rr_after_wrap", 30);
    chk("rr_after_wrap_first", (grant_log.size() == 2) ? 32'(grant_log[0]) : 32'hFFFF_FFFF, 32'd2);
    chk("rr_after_wrap_second", (grant_log.size() == 2) ? 32'(grant_log[1]) : 32'hFFFF_FFFF, 32'd1);

`ifdef LOGIC_ARB_STATS_EN
    // Grant counters: requester 0 saturates at 3 with CW=2, others stay 0.
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      drive(0, OP_XOR, W'(k), 8'h00);
      push_exp(0, W'(k));
      wait_drain("stats", 20);
      chk("grant_cnt", 32'(grant_cnt), (k < 3) ? 32'(k) : 32'd3);
    end
`endif

    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
